// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared definitions for the FP adder sequencer: exception
//                flag bit positions, rounding-mode codes, the canonical quiet
//                NaN and the sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    // Exception flag vector layout: {inv, ov, un, inexact}
    localparam int NUM_FLAGS = 4;
    localparam int FLG_INV   = 3;
    localparam int FLG_OV    = 2;
    localparam int FLG_UN    = 1;
    localparam int FLG_NX    = 0;

    // Rounding-mode codes shared with the adder's round_m input
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RZ  = 3'b001;
    localparam logic [2:0] RM_RD  = 3'b010;
    localparam logic [2:0] RM_RU  = 3'b011;
    localparam logic [2:0] RM_RNA = 3'b100;

    // Canonical single-precision quiet NaN produced by invalid operations
    localparam logic [31:0] FP_NANQ = 32'h7FC0_0000;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    // Assemble the individual adder flags into the shared flag layout
    function automatic logic [NUM_FLAGS-1:0] pack_flags(
        input logic inv,
        input logic ov,
        input logic un,
        input logic nx
    );
        logic [NUM_FLAGS-1:0] f;
        f          = '0;
        f[FLG_INV] = inv;
        f[FLG_OV]  = ov;
        f[FLG_UN]  = un;
        f[FLG_NX]  = nx;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_flag_acc.sv
`default_nettype none
// ============================================================================
//  Module      : fp_flag_acc
//  Description : Sticky exception-flag accumulator with software clear.
//                A set coincident with a clear leaves exactly the new flags,
//                so no exception raised in the clearing cycle is lost.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_flag_acc
    import fp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 set_en,
    input  logic [NUM_FLAGS-1:0] set_flags,
    output logic [NUM_FLAGS-1:0] flags
);

    logic [NUM_FLAGS-1:0] r_flags;

    // Accumulate on set; the clear is applied before OR-ing in the new flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= '0;
        end else if (set_en) begin
            r_flags <= (clr ? '0 : r_flags) | set_flags;
        end else if (clr) begin
            r_flags <= '0;
        end
    end

    assign flags = r_flags;

endmodule
`default_nettype wire

// File: rtl/fp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_seq
//  Description : Request/response sequencer in front of the pipelined FP
//                adder. Accepts one operation over valid/ready, holds the
//                operands while the adder runs for LAT edges, captures the
//                result and flags, and returns them over a second
//                valid/ready handshake. Keeps a sticky fflags accumulation.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_add_seq
    import fp_pkg::*;
#(
    parameter int W   = 32,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic [2:0]   req_rm,

    output logic [W-1:0] add_in1,
    output logic [W-1:0] add_in2,
    output logic [2:0]   add_rm,
    output logic         add_enable,
    input  logic [W-1:0] add_out,
    input  logic         add_ov,
    input  logic         add_un,
    input  logic         add_inv,
    input  logic         add_inexact,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic [3:0]   rsp_flags,

    output logic [3:0]   fflags,
    input  logic         fflags_clr
);

    // Counter only has to reach LAT; it is cleared on every accept so it
    // never wraps.
    localparam int            CW         = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [CW-1:0] c_CNT_DONE = CW'(LAT);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [W-1:0]       r_op_a;
    logic [W-1:0]       r_op_b;
    logic [2:0]         r_rm;
    logic [W-1:0]       r_result;
    logic [3:0]         r_rsp_flags;
    logic [3:0]         w_cap_flags;
    logic               w_req_ready;
    logic               w_add_enable;
    logic               w_rsp_valid;
    logic               w_accept;
    logic               w_capture;

    assign w_cap_flags = pack_flags(add_inv, add_ov, add_un, add_inexact);
    assign w_accept    = req_valid && w_req_ready;
    assign w_capture   = (r_state == BUSY) && (r_cnt == c_CNT_DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake/enable outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_req_ready  = 1'b0;
        w_add_enable = 1'b0;
        w_rsp_valid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_add_enable = 1'b1;
                if (r_cnt == c_CNT_DONE) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                // Response consumed: a waiting request bypasses IDLE
                w_req_ready = rsp_ready;
                if (rsp_ready) begin
                    w_state_nxt = req_valid ? BUSY : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Never advertise readiness while reset is held
        if (rst) begin
            w_req_ready = 1'b0;
        end
    end

    // Operand capture on accept and latency counting while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_op_a <= '0;
            r_op_b <= '0;
            r_rm   <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_op_a <= req_a;
            r_op_b <= req_b;
            r_rm   <= req_rm;
        end else if ((r_state == BUSY) && !w_capture) begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    // Result and flag capture; held until the response is consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result    <= '0;
            r_rsp_flags <= '0;
        end else if (w_capture) begin
            r_result    <= add_out;
            r_rsp_flags <= w_cap_flags;
        end
    end

    fp_flag_acc u_flag_acc (
        .clk       (clk),
        .rst       (rst),
        .clr       (fflags_clr),
        .set_en    (w_capture),
        .set_flags (w_cap_flags),
        .flags     (fflags)
    );

    assign req_ready  = w_req_ready;
    assign add_enable = w_add_enable;
    assign rsp_valid  = w_rsp_valid;
    assign add_in1    = r_op_a;
    assign add_in2    = r_op_b;
    assign add_rm     = r_rm;
    assign rsp_result = r_result;
    assign rsp_flags  = r_rsp_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_add_seq
//  Description : Self-checking bench for fp_add_seq. A stand-in adder with a
//                LAT-deep enabled pipeline feeds the sequencer; a scoreboard
//                checks every delivered response against the operands that
//                were accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_seq;

    localparam int W   = 32;
    localparam int LAT = 2;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [2:0]   req_rm;
    logic [W-1:0] add_in1;
    logic [W-1:0] add_in2;
    logic [2:0]   add_rm;
    logic         add_enable;
    logic [W-1:0] add_out;
    logic         add_ov;
    logic         add_un;
    logic         add_inv;
    logic         add_inexact;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic [3:0]   fflags;
    logic         fflags_clr;

    int total;
    int bad;

    fp_add_seq #(.W(W), .LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_rm      (req_rm),
        .add_in1     (add_in1),
        .add_in2     (add_in2),
        .add_rm      (add_rm),
        .add_enable  (add_enable),
        .add_out     (add_out),
        .add_ov      (add_ov),
        .add_un      (add_un),
        .add_inv     (add_inv),
        .add_inexact (add_inexact),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .fflags      (fflags),
        .fflags_clr  (fflags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference adder behaviour: exact answers for the IEEE cases used in the
    // directed tests, a scrambling function for everything else.
    // Returns {result, inv, ov, un, inexact}.
    function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] rm);
        if (a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 4'b0000};
        if (a == 32'h3F800000 && b == 32'h3F800000) return {32'h40000000, 4'b0000};
        if (a == 32'h7F800000 && b == 32'hFF800000) return {32'h7FC00000, 4'b1000};
        if (a == 32'h3F800000 && b == 32'h30800000)
            return {(rm == fp_pkg::RM_RU) ? 32'h3F800001 : 32'h3F800000, 4'b0001};
        return {(a + {b[7:0], b[31:8]}) ^ {29'd0, rm}, a[3:0] ^ b[7:4] ^ {1'b0, rm}};
    endfunction

    // Stand-in for the pipelined adder: advances only while enabled
    logic [35:0] p1;
    logic [35:0] p2;
    initial begin
        p1 = '0;
        p2 = '0;
    end
    always @(posedge clk) begin
        if (add_enable) begin
            p1 <= ref_add(add_in1, add_in2, add_rm);
            p2 <= p1;
        end
    end
    assign add_out = p2[35:4];
    assign {add_inv, add_ov, add_un, add_inexact} = p2[3:0];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: expectations are pushed on accept, popped on delivery
    logic [35:0] sb_q[$];
    logic [35:0] sb_e;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("sb_result", rsp_result, sb_e[35:4]);
                    chk("sb_flags", rsp_flags, sb_e[3:0]);
                end
            end
            if (req_valid && req_ready) sb_q.push_back(ref_add(req_a, req_b, req_rm));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full operation; optionally pulses fflags_clr on the capture edge
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                          input bit clr_cap, output logic [31:0] res, output logic [3:0] fl,
                          output int lat, output int en);
        int guard;
        req_a = a; req_b = b; req_rm = rm; req_valid = 1'b1; rsp_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 20) begin step(); guard++; end
        chk("op_accept_timeout", guard < 20, 1);
        step();
        req_valid = 1'b0;
        lat = 0; en = 0;
        while (!rsp_valid && lat < 20) begin
            if (add_enable) en++;
            fflags_clr = clr_cap && (lat == LAT);
            step();
            lat++;
        end
        fflags_clr = 1'b0;
        res = rsp_result;
        fl  = rsp_flags;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int guard;
        guard = 0;
        while (!rsp_valid && guard < 20) begin step(); guard++; end
        chk(name, rsp_valid, 1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        bit          clr;
        logic [31:0] res;
        logic [3:0]  fl;
        logic [3:0]  ff;
    } vec_t;

    vec_t vt[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        logic [3:0]  fl;
        logic [3:0]  acc;
        logic [35:0] exp;
        int          lat;
        int          en;
        int          guard;
        int          seen;

        total = 0; bad = 0;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_rm = '0;
        rsp_ready = 1'b0; fflags_clr = 1'b0;

        vt[0] = '{32'h3F800000, 32'h40000000, fp_pkg::RM_RNE, 1'b0, 32'h40400000, 4'b0000, 4'b0000};
        vt[1] = '{32'h7F800000, 32'hFF800000, fp_pkg::RM_RNE, 1'b0, 32'h7FC00000, 4'b1000, 4'b1000};
        vt[2] = '{32'h3F800000, 32'h3F800000, fp_pkg::RM_RNE, 1'b0, 32'h40000000, 4'b0000, 4'b1000};
        vt[3] = '{32'h3F800000, 32'h30800000, fp_pkg::RM_RNE, 1'b1, 32'h3F800000, 4'b0001, 4'b0001};
        vt[4] = '{32'h3F800000, 32'h30800000, fp_pkg::RM_RU,  1'b0, 32'h3F800001, 4'b0001, 4'b0001};
        vt[5] = '{32'h3F800000, 32'h40000000, fp_pkg::RM_RZ,  1'b0, 32'h40400000, 4'b0000, 4'b0001};

        // Reset state
        step(); step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_fflags", fflags, 0);
        chk("rst_add_enable", add_enable, 0);
        chk("rst_add_in1", add_in1, 0);
        rst = 1'b0;
        step();
        chk("rst_release_ready", req_ready, 1);

        // Table-driven operations
        for (int i = 0; i < 6; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].rm, vt[i].clr, res, fl, lat, en);
            chk($sformatf("vec%0d_result", i), res, vt[i].res);
            chk($sformatf("vec%0d_flags", i), fl, vt[i].fl);
            chk($sformatf("vec%0d_latency", i), lat, LAT + 1);
            chk($sformatf("vec%0d_enable_cycles", i), en, LAT + 1);
            chk($sformatf("vec%0d_fflags", i), fflags, vt[i].ff);
        end

        // Stand-alone clear
        fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
        chk("clr_alone_fflags", fflags, 0);

        // Backpressure with a pending request, then same-cycle accept
        req_a = 32'h3F800000; req_b = 32'h40000000; req_rm = fp_pkg::RM_RNE;
        req_valid = 1'b1; rsp_ready = 1'b0;
        step();
        req_b = 32'h3F800000;
        wait_rsp("bp_rsp_timeout");
        for (int k = 0; k < 5; k++) begin
            chk("bp_req_ready", req_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_result", rsp_result, 32'h40400000);
            chk("bp_rsp_flags", rsp_flags, 0);
            chk("bp_add_in1", add_in1, 32'h3F800000);
            chk("bp_add_in2", add_in2, 32'h40000000);
            chk("bp_add_enable", add_enable, 0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 1);
        step();
        req_valid = 1'b0; rsp_ready = 1'b0;
        chk("bp_bypass_busy", add_enable, 1);
        chk("bp_bypass_rsp_valid", rsp_valid, 0);
        chk("bp_bypass_in2", add_in2, 32'h3F800000);
        wait_rsp("bp2_rsp_timeout");
        chk("bp2_result", rsp_result, 32'h40000000);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

        // Operand change during BUSY has no effect
        req_a = 32'h3F800000; req_b = 32'h40000000; req_rm = fp_pkg::RM_RNE; req_valid = 1'b1;
        step();
        req_valid = 1'b0; req_a = 32'h7F800000; req_b = 32'hFF800000;
        for (int k = 0; k < LAT; k++) begin
            chk("hold_add_in1", add_in1, 32'h3F800000);
            chk("hold_add_in2", add_in2, 32'h40000000);
            step();
        end
        wait_rsp("hold_rsp_timeout");
        chk("hold_result", rsp_result, 32'h40400000);
        chk("hold_flags", rsp_flags, 0);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

        // Reset in BUSY cycle 1 drops the operation
        run_op(32'h7F800000, 32'hFF800000, fp_pkg::RM_RNE, 1'b0, res, fl, lat, en);
        req_a = 32'h3F800000; req_b = 32'h40000000; req_rm = fp_pkg::RM_RU; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_rsp_result", rsp_result, 0);
        chk("midrst_rsp_flags", rsp_flags, 0);
        chk("midrst_fflags", fflags, 0);
        chk("midrst_add_enable", add_enable, 0);
        chk("midrst_add_in1", add_in1, 0);
        chk("midrst_add_in2", add_in2, 0);
        chk("midrst_add_rm", add_rm, 0);
        chk("midrst_req_ready", req_ready, 0);
        step(); step();
        rst = 1'b0;
        step();
        chk("midrst_release_ready", req_ready, 1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid) seen++;
            step();
        end
        chk("midrst_no_response", seen, 0);

        // Randomized traffic with random backpressure and bypass
        fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
        acc = '0;
        for (int i = 0; i < 40; i++) begin
            req_a = $urandom; req_b = $urandom; req_rm = 3'($urandom_range(0, 4));
            exp = ref_add(req_a, req_b, req_rm);
            req_valid = 1'b1;
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            guard = 0;
            while (!req_ready && guard < 50) begin
                step();
                rsp_ready = 1'($urandom_range(0, 1));
                #1;
                guard++;
            end
            chk("rnd_accept_timeout", guard < 50, 1);
            step();
            req_valid = 1'b0; rsp_ready = 1'b0;
            wait_rsp("rnd_rsp_timeout");
            acc = acc | exp[3:0];
            chk("rnd_fflags", fflags, acc);
            repeat ($urandom_range(0, 3)) step();
        end
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        chk("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
